// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared constants for the system ID register block: register offsets,
// CAPS word layout and CTRL command bit.
package first_nios2_system_sysid_pkg;

  // Word offsets decoded on the register bus
  typedef enum logic [3:0] {
    REG_ID         = 4'd0,
    REG_TIMESTAMP  = 4'd1,
    REG_CAPS       = 4'd2,
    REG_UPTIME_LO  = 4'd3,
    REG_UPTIME_HI  = 4'd4,
    REG_CTRL       = 4'd5,
    REG_SCRATCH0   = 4'd8
  } reg_offset_e;

  // CAPS field positions
  localparam int CAPS_NUM_SCRATCH_LSB = 0;
  localparam int CAPS_NUM_SCRATCH_W   = 3;
  localparam int CAPS_UPTIME_W_LSB    = 8;
  localparam int CAPS_UPTIME_W_W      = 8;

  // CTRL bit that zeroes the uptime counter when written as 1
  localparam int CTRL_CLEAR_BIT = 0;

  // Builds the read-only CAPS word from the elaboration parameters
  function automatic logic [31:0] caps_word(input int unsigned uptime_w,
                                            input int unsigned num_scratch);
    logic [31:0] w;
    w = '0;
    w[CAPS_UPTIME_W_LSB +: CAPS_UPTIME_W_W]       = uptime_w[CAPS_UPTIME_W_W-1:0];
    w[CAPS_NUM_SCRATCH_LSB +: CAPS_NUM_SCRATCH_W] = num_scratch[CAPS_NUM_SCRATCH_W-1:0];
    return w;
  endfunction

endpackage

// File: rtl/first_nios2_system_sysid_uptime.sv
// Free-running uptime counter with a high-half snapshot register so that a
// 32-bit master can read a coherent LO/HI pair.
module first_nios2_system_sysid_uptime
  import first_nios2_system_sysid_pkg::*;
#(
  parameter int UPTIME_W = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        snap,
  output logic [31:0] lo,
  output logic [31:0] hi_snap
);

  logic [UPTIME_W-1:0]  count;
  logic [UPTIME_W-33:0] hi_reg;

  // Counter advances every cycle and wraps silently; clear wins over counting
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else begin
      count <= count + UPTIME_W'(1);
    end
  end

  // Capture the upper bits whenever LO is read so HI reads are coherent
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_reg <= '0;
    end else if (snap) begin
      hi_reg <= count[UPTIME_W-1:32];
    end
  end

  assign lo      = count[31:0];
  assign hi_snap = 32'(hi_reg);

endmodule

// File: rtl/first_nios2_system_sysid_regs.sv
// System ID register block: constant ID/timestamp/CAPS words, an uptime
// counter with coherent LO/HI reads, a clear command and scratch registers.
// Reads return one cycle later with a readdatavalid pulse.
module first_nios2_system_sysid_regs
  import first_nios2_system_sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'h5552_BEFD,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int          NUM_SCRATCH = 2,
  parameter int          UPTIME_W    = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic        rd_accept;
  logic        clear_cmd;
  logic        snap_cmd;
  logic [31:0] uptime_lo;
  logic [31:0] uptime_hi;
  logic [31:0] rd_mux;
  logic        valid_q;
  logic [31:0] scratch [NUM_SCRATCH];

  // A write always wins over a simultaneous read, which is then dropped
  assign rd_accept = read && !write;
  assign clear_cmd = write && (address == REG_CTRL) && byteenable[0]
                     && writedata[CTRL_CLEAR_BIT];
  assign snap_cmd  = rd_accept && (address == REG_UPTIME_LO);

  first_nios2_system_sysid_uptime #(
    .UPTIME_W (UPTIME_W)
  ) u_uptime (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear_cmd),
    .snap    (snap_cmd),
    .lo      (uptime_lo),
    .hi_snap (uptime_hi)
  );

  // Scratch registers update per byte lane at the write edge
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch[i] <= '0;
      end
    end else if (write) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        for (int b = 0; b < 4; b++) begin
          if ((address == 4'(int'(REG_SCRATCH0) + i)) && byteenable[b]) begin
            scratch[i][8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read decode; CTRL and unmapped offsets return zero
  always_comb begin
    rd_mux = '0;
    case (address)
      REG_ID:        rd_mux = ID_VALUE;
      REG_TIMESTAMP: rd_mux = TIMESTAMP;
      REG_CAPS:      rd_mux = caps_word(UPTIME_W, NUM_SCRATCH);
      REG_UPTIME_LO: rd_mux = uptime_lo;
      REG_UPTIME_HI: rd_mux = uptime_hi;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (address == 4'(int'(REG_SCRATCH0) + i)) begin
            rd_mux = scratch[i];
          end
        end
      end
    endcase
  end

  // Read pipeline register; readdata holds between accepted reads
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= rd_accept;
      if (rd_accept) begin
        readdata <= rd_mux;
      end
    end
  end

  // A response still in flight when reset rises is suppressed immediately
  assign readdatavalid = valid_q && !reset;

endmodule

// File: doc/first_nios2_system_sysid_regs.md
FIRST_NIOS2_SYSTEM_SYSID_REGS -- requirements
Module: first_nios2_system_sysid_regs

Interface
REQ-001 Parameter ID_VALUE, default 32'h5552_BEFD, meaning system ID returned at offset 0.
REQ-002 Parameter TIMESTAMP, default 0, meaning build timestamp returned at offset 1.
REQ-003 Parameter NUM_SCRATCH, default 2, range 1..4, meaning number of read/write scratch registers.
REQ-004 Parameter UPTIME_W, default 48, range 33..64, meaning uptime counter width.
REQ-005 Ports SHALL be, clock and reset first:
  clock  in  1  single clock, all logic rising-edge.
  reset  in  1  synchronous, active-high reset.
  address  in  4  word offset.
  read  in  1  read strobe.
  write  in  1  write strobe.
  byteenable  in  4  write byte lanes.
  writedata  in  32  write data.
  readdata  out  32  read data, registered.
  readdatavalid  out  1  one-cycle pulse qualifying readdata.

Function
REQ-006 Map: 0 ID (RO), 1 TIMESTAMP (RO), 2 CAPS (RO), 3 UPTIME_LO (RO), 4 UPTIME_HI (RO), 5 CTRL (W1C-style command), 8..8+NUM_SCRATCH-1 SCRATCH (RW).
REQ-007 CAPS SHALL read {16'h0, UPTIME_W[7:0], 5'h0, NUM_SCRATCH[2:0]}.
REQ-008 Read latency SHALL be exactly 1 cycle: read in cycle N, readdata valid with readdatavalid=1 in cycle N+1, and readdatavalid=0 otherwise.
REQ-009 Back-to-back reads SHALL be accepted every cycle without stall; no waitrequest exists.
REQ-010 Unmapped offsets (6, 7, 8+NUM_SCRATCH..15) SHALL read 0 with readdatavalid=1; writes to them SHALL have no effect.
REQ-011 Writes SHALL take effect at the clock edge of the write cycle; only lanes with byteenable=1 SHALL update SCRATCH bytes.
REQ-012 Writes to offsets 0..4 SHALL be ignored.
REQ-013 The uptime counter SHALL increment by 1 every cycle outside reset and wrap from 2^UPTIME_W-1 to 0 without flagging.
REQ-014 A read of UPTIME_LO SHALL return counter bits [31:0] sampled in the read cycle and simultaneously capture bits [UPTIME_W-1:32] into a HI snapshot register.
REQ-015 UPTIME_HI reads SHALL return the HI snapshot zero-extended, never the live counter.
REQ-016 Writing CTRL with writedata[0]=1 and byteenable[0]=1 SHALL zero the counter at that edge. CTRL SHALL read 0.
REQ-017 A clear and a UPTIME_LO read in the same cycle SHALL return the pre-clear value. This case is reachable only across cycles, because read and write are exclusive per REQ-018.
REQ-018 If read and write are both asserted, the write SHALL be performed and the read dropped (no readdatavalid).
REQ-019 readdata SHALL hold its last value when readdatavalid=0.

Reset
REQ-020 On reset=1 at a clock edge: readdata=0, readdatavalid=0, uptime counter=0, HI snapshot=0, all SCRATCH=0.
REQ-021 A read issued in the cycle reset is asserted SHALL produce no readdatavalid.
REQ-022 A read in flight (issued cycle N, reset at N+1) SHALL be cancelled: readdatavalid=0.
REQ-023 The counter SHALL resume from 0 on the first cycle after reset deasserts.

Structure
REQ-024 Package first_nios2_system_sysid_pkg SHALL hold the register offset constants, the CAPS field positions and the CTRL bit position.
REQ-025 The uptime counter plus HI snapshot SHALL be the sub-module first_nios2_system_sysid_uptime (inputs clear, snap; outputs lo[31:0], hi_snap[31:0]).
REQ-026 The top level SHALL hold the decode, SCRATCH registers and read pipeline, with no other sub-modules.

Verification
REQ-027 After reset, read offsets 0, 1, 2 back-to-back -> three consecutive readdatavalid pulses with 5552BEFD, 00000000, 00003002 (defaults).
REQ-028 Write SCRATCH0 = A5A5A5A5 with byteenable=4'b0101, then read -> 00A500A5. Write offset 0 = FFFFFFFF -> ID unchanged.
REQ-029 Force counter to 0x0000_FFFF_FFFF, read LO then HI -> FFFFFFFF then 00000000. A later HI read without a LO read SHALL still return 00000000 although the live counter is 1_0000_0000+.
REQ-030 Read with write asserted in the same cycle to SCRATCH1 = 12345678 -> no readdatavalid; next read of SCRATCH1 -> 12345678.
REQ-031 Issue a read, assert reset the next cycle -> readdatavalid stays 0 and all SCRATCH read 0 afterwards. Write CTRL=1, then read LO two cycles later -> 00000001.
REQ-032 Read offsets 6 and 15 -> 00000000 with readdatavalid=1.
